// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// ALU results win by default; buffered load results drain when the ALU is idle or starved.
module wb_arbiter #(
    parameter int LQ_DEPTH = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        wren,
    output logic [4:0]  wr,
    output logic [31:0] wd,
    output logic [31:0] pending
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    r_q_rd   [LQ_DEPTH];
    logic [31:0]   r_q_data [LQ_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic [WW-1:0] r_wait;
    logic          r_wren;
    logic [4:0]    r_wr;
    logic [31:0]   r_wd;

    logic          w_empty, w_full, w_force;
    logic          w_push, w_pop, w_alu_gnt;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_pending;

    always_comb begin
        w_empty    = (r_cnt == '0);
        w_full     = (r_cnt == (AW+1)'(LQ_DEPTH));
        w_force    = !w_empty && (r_wait == WW'(MAX_WAIT));
        // No same-cycle dequeue credit: readiness depends only on stored occupancy.
        w_push     = mem_valid && !w_full;
        w_pop      = w_force || (!alu_valid && !w_empty);
        w_alu_gnt  = alu_valid && !w_force;
        w_sel_rd   = w_pop ? r_q_rd[r_rp]   : alu_rd;
        w_sel_data = w_pop ? r_q_data[r_rp] : alu_data;
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - r_rp)} < r_cnt)
                w_pending[r_q_rd[i]] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wp]   <= mem_rd;
            r_q_data[r_wp] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_wait <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // Any non-popping cycle with a head present means the ALU took the port.
            if (w_empty || w_pop)
                r_wait <= '0;
            else if (r_wait != WW'(MAX_WAIT))
                r_wait <= r_wait + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren <= 1'b0;
            r_wr   <= '0;
            r_wd   <= '0;
        end else if (w_pop || w_alu_gnt) begin
            r_wren <= (w_sel_rd != 5'd0);
            r_wr   <= w_sel_rd;
            r_wd   <= w_sel_data;
        end else begin
            r_wren <= 1'b0;
        end
    end

    assign alu_ready = !w_force;
    assign mem_ready = !w_full;
    assign wren      = r_wren;
    assign wr        = r_wr;
    assign wd        = r_wd;
    assign pending   = w_pending;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued in grant order and
// matched against every observed register-file write.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, wren;
    logic [4:0]  wr;
    logic [31:0] wd, pending;

    typedef struct packed { logic [4:0] rd; logic [31:0] d; } wr_t;
    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    wb_arbiter #(.LQ_DEPTH(4), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wren(wren), .wr(wr), .wd(wd), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back('{rd: rd, d: d});
    endtask

    // Every write seen on the port must be the next one the scoreboard predicts.
    always @(negedge clk) begin
        if (mon_en && !rst && wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_wr", {27'd0, wr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_wr", {27'd0, wr}, {27'd0, e.rd});
                chk("sb_wd", wd, e.d);
            end
        end
    end

    initial begin
        logic [31:0] pm;
        rst = 1'b1; alu_valid = 0; mem_valid = 0;
        alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wren", {31'd0, wren}, 32'd0);
        chk("rst_wr", {27'd0, wr}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        mon_en = 1'b1;

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
        chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
        expect_wr(5, 32'hDEADBEEF);
        tick(); alu_valid = 0;
        chk("t1_wren", {31'd0, wren}, 32'd1);
        chk("t1_wr", {27'd0, wr}, 32'd5);
        chk("t1_wd", wd, 32'hDEADBEEF);

        // Load only: two-cycle latency, visible in pending for one cycle
        mem_valid = 1; mem_rd = 7; mem_data = 32'h1234; #1;
        chk("t2_mem_ready", {31'd0, mem_ready}, 32'd1);
        expect_wr(7, 32'h1234);
        tick(); mem_valid = 0; #1;
        chk("t2_pending_n1", pending, 32'h80);
        chk("t2_wren_n1", {31'd0, wren}, 32'd0);
        tick();
        chk("t2_wren_n2", {31'd0, wren}, 32'd1);
        chk("t2_wr_n2", {27'd0, wr}, 32'd7);
        chk("t2_pending_n2", pending, 32'd0);
        tick();

        // Starvation: three ALU wins, then one forced drain
        mem_valid = 1; mem_rd = 3; mem_data = 32'h33;
        tick(); mem_valid = 0;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1; alu_rd = 5'(10 + k); alu_data = 32'hA000 + k; #1;
            chk("t3_alu_ready", {31'd0, alu_ready}, 32'd1);
            chk("t3_pending", pending, 32'h8);
            expect_wr(5'(10 + k), 32'hA000 + k);
            tick();
        end
        alu_rd = 13; alu_data = 32'hA003; #1;
        chk("t3_forced_alu_ready", {31'd0, alu_ready}, 32'd0);
        expect_wr(3, 32'h33);
        tick(); #1;
        chk("t3_resume_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("t3_pending_after", pending, 32'd0);
        expect_wr(13, 32'hA003);
        tick(); alu_valid = 0;
        tick();

        // Full FIFO while the ALU saturates the port
        pm = 32'd0;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1; alu_rd = 5'(8 + k); alu_data = 32'hB000 + k;
            mem_valid = 1; mem_rd = 5'(21 + k); mem_data = 32'hC000 + k; #1;
            chk("t4_alu_ready", {31'd0, alu_ready}, 32'd1);
            chk("t4_mem_ready", {31'd0, mem_ready}, 32'd1);
            chk("t4_pending_fill", pending, pm);
            expect_wr(5'(8 + k), 32'hB000 + k);
            pm[21 + k] = 1'b1;
            tick();
        end
        alu_rd = 12; alu_data = 32'hB004; mem_rd = 25; mem_data = 32'hC004; #1;
        chk("t4_full_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("t4_full_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("t4_pending_full", pending, 32'h01E0_0000);
        expect_wr(21, 32'hC000);
        tick(); #1;
        chk("t4_mem_ready_after_pop", {31'd0, mem_ready}, 32'd1);
        chk("t4_alu_ready_new_head", {31'd0, alu_ready}, 32'd1);
        chk("t4_pending_pop1", pending, 32'h01C0_0000);
        expect_wr(12, 32'hB004);
        tick(); alu_valid = 0; mem_valid = 0; #1;
        chk("t4_pending_refill", pending, 32'h03C0_0000);
        for (int k = 1; k < 5; k++) expect_wr(5'(21 + k), 32'hC000 + k);
        for (int k = 0; k < 6; k++) tick();
        chk("t4_pending_drained", pending, 32'd0);

        // x0 destination is consumed but never written
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF; #1;
        chk("t5_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick(); alu_valid = 0;
        chk("t5_wren", {31'd0, wren}, 32'd0);
        tick();

        // Reset with two queued loads discards them
        alu_valid = 1; alu_rd = 0; alu_data = 0;
        mem_valid = 1; mem_rd = 17; mem_data = 32'hD017;
        tick();
        mem_rd = 18; mem_data = 32'hD018;
        tick(); mem_valid = 0; #1;
        chk("t6_pending_queued", pending, 32'h0006_0000);
        rst = 1'b1;
        tick(); rst = 1'b0; alu_valid = 0; #1;
        chk("t6_wren", {31'd0, wren}, 32'd0);
        chk("t6_pending", pending, 32'd0);
        chk("t6_mem_ready", {31'd0, mem_ready}, 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("t6_wren_idle", {31'd0, wren}, 32'd0);

        chk("sb_all_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
